// File: rtl/dmem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_pkg: shared types and the byte-merge helper for dmem_arbiter |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package dmem_pkg;

    localparam int BE_W       = 4;
    localparam int MAX_DATA_W = 64;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RMW  = 1'b1
    } arb_state_t;

    // Fixed at the widest supported word; callers zero-extend and truncate.
    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0]   old_word,
        input logic [MAX_DATA_W-1:0]   new_word,
        input logic [MAX_DATA_W/8-1:0] be
    );
        logic [MAX_DATA_W-1:0] merged;
        merged = old_word;
        for (int k = 0; k < MAX_DATA_W/8; k++) begin
            if (be[k]) begin
                merged[k*8 +: 8] = new_word[k*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arbiter: combinational round-robin one-hot grant from a pointer |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int PTR_W = 1
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [PTR_W-1:0] ptr,
    input  logic             enable,
    output logic [NREQ-1:0]  grant
);

    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PTR_W'((int'(ptr) + k) % NREQ);
            if (enable && !found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_arbiter: round-robin sharing of a single-port data memory,   |
// | partial stores via read-modify-write. Option: DMEM_ARBITER_STATS_EN |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ-1:0]            req_we,
    input  logic [NREQ*32-1:0]         req_addr,
    input  logic [NREQ*DATA_W-1:0]     req_wdata,
    input  logic [NREQ*(DATA_W/8)-1:0] req_be,
    output logic [NREQ-1:0]            rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic                       mem_we,
    input  logic [DATA_W-1:0]          mem_rdata
`ifdef DMEM_ARBITER_STATS_EN
    ,
    output logic [NREQ*32-1:0]         stat_grants
`endif
);

    localparam int NBE   = DATA_W / 8;
    localparam int PTR_W = $clog2(NREQ);

    arb_state_t       state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] sel;
    logic [NREQ-1:0]  grant;
    logic             accept;

    logic [31:0]       addr_arr  [NREQ];
    logic [DATA_W-1:0] wdata_arr [NREQ];
    logic [NBE-1:0]    be_arr    [NREQ];

    logic              sel_we;
    logic [ADDR_W-1:0] sel_idx;
    logic [DATA_W-1:0] sel_wdata;
    logic [NBE-1:0]    sel_be;
    logic              full_be;
    logic              partial;

    logic [ADDR_W-1:0] rmw_idx;
    logic [DATA_W-1:0] rmw_wdata;
    logic [DATA_W-1:0] rmw_old;
    logic [NBE-1:0]    rmw_be;
    logic [DATA_W-1:0] merged;

    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*32 +: 32];
        assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
        assign be_arr[g]    = req_be[g*NBE +: NBE];
    end

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .valid  (req_valid),
        .ptr    (rr_ptr),
        .enable (state == IDLE && !rst),
        .grant  (grant)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel = PTR_W'(i);
            end
        end
    end

    assign accept    = |grant;
    assign req_ready = grant;
    assign sel_we    = req_we[sel];
    assign sel_idx   = addr_arr[sel][ADDR_W+1:2];
    assign sel_wdata = wdata_arr[sel];
    assign sel_be    = be_arr[sel];
    assign full_be   = &sel_be;
    assign partial   = sel_we && (|sel_be) && !full_be;
    assign merged    = DATA_W'(byte_merge(MAX_DATA_W'(rmw_old), MAX_DATA_W'(rmw_wdata),
                                          (MAX_DATA_W/8)'(rmw_be)));

    // The RMW write owns the memory port; arbitration is disabled meanwhile.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (state == RMW) begin
            mem_addr  = rmw_idx;
            mem_wdata = merged;
            mem_we    = !rst;
        end else if (accept) begin
            mem_addr = sel_idx;
            if (sel_we && full_be) begin
                mem_wdata = sel_wdata;
                mem_we    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rmw_idx   <= '0;
            rmw_wdata <= '0;
            rmw_old   <= '0;
            rmw_be    <= '0;
        end else begin
            rsp_valid <= '0;
            if (state == RMW) begin
                state <= IDLE;
            end
            if (accept) begin
                rr_ptr <= (sel == PTR_W'(NREQ-1)) ? '0 : sel + PTR_W'(1);
                if (!sel_we) begin
                    rsp_valid <= grant;
                    rsp_rdata <= mem_rdata;
                end else if (partial) begin
                    state     <= RMW;
                    rmw_idx   <= sel_idx;
                    rmw_wdata <= sel_wdata;
                    rmw_be    <= sel_be;
                    rmw_old   <= mem_rdata;
                end
            end
        end
    end

`ifdef DMEM_ARBITER_STATS_EN
    for (genvar g = 0; g < NREQ; g++) begin : g_stats
        logic [31:0] cnt;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
            end else if (grant[g] && cnt != '1) begin
                cnt <= cnt + 32'd1;
            end
        end
        assign stat_grants[g*32 +: 32] = cnt;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_dmem_arbiter: randomized and directed bench with a reference    |
// | model of arbitration, memory contents and load responses. Rev 1.0  |
// +------------------------------------------------------------------+
module tb_dmem_arbiter;

    localparam int NREQ   = 2;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int DEPTH  = 128;

    typedef logic [0:0] rid_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                   t_valid [NREQ];
    logic                   t_we    [NREQ];
    logic [31:0]            t_addr  [NREQ];
    logic [DATA_W-1:0]      t_wdata [NREQ];
    logic [BE_W-1:0]        t_be    [NREQ];

    logic [NREQ-1:0]        req_valid, req_ready, req_we, rsp_valid;
    logic [NREQ*32-1:0]     req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ*BE_W-1:0]   req_be;
    logic [DATA_W-1:0]      rsp_rdata, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0]      mem_addr;
    logic                   mem_we;
`ifdef DMEM_ARBITER_STATS_EN
    logic [NREQ*32-1:0]     stat_grants;
`endif

    assign req_valid = {t_valid[1], t_valid[0]};
    assign req_we    = {t_we[1], t_we[0]};
    assign req_addr  = {t_addr[1], t_addr[0]};
    assign req_wdata = {t_wdata[1], t_wdata[0]};
    assign req_be    = {t_be[1], t_be[0]};

    dmem_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
`ifdef DMEM_ARBITER_STATS_EN
        ,
        .stat_grants (stat_grants)
`endif
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'h9E37_79B9 * 32'(i + 1);
    endfunction

    // Physical memory attached to the DUT
    logic [31:0] dmem [DEPTH];
    logic        mem_init;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) dmem[7'(i)] <= init_word(i);
        end else if (mem_we) begin
            dmem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = dmem[mem_addr];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge_ref(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    // Reference model state
    logic [31:0]       ref_mem [DEPTH];
    rid_t              m_ptr;
    bit                m_busy;
    logic [ADDR_W-1:0] m_idx;
    logic [31:0]       m_merged;
    logic [NREQ-1:0]   m_rsp_v;
    logic [31:0]       m_rsp_d;
    bit                m_fresh;
    int                m_cnt [NREQ];
    int                dut_log [$];

    logic [NREQ-1:0]   e_ready;
    logic              e_we, e_found;
    logic [ADDR_W-1:0] e_addr;
    logic [31:0]       e_wdata, e_w;
    logic [3:0]        e_b;
    rid_t              e_acc, cand;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req_ready", 64'(req_ready), 64'd0);
            chk("rst_mem_we", 64'(mem_we), 64'd0);
            chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
`ifdef DMEM_ARBITER_STATS_EN
            chk("rst_stat_grants", 64'(stat_grants), 64'd0);
`endif
            m_cnt[0] = 0;
            m_cnt[1] = 0;
            m_ptr    = '0;
            m_busy   = 0;
            m_rsp_v  = '0;
            m_rsp_d  = '0;
            m_fresh  = 1;
        end else begin
            chk("rsp_valid", 64'(rsp_valid), 64'(m_rsp_v));
            if (m_rsp_v != '0 || m_fresh) chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rsp_d));
            m_fresh = 0;
`ifdef DMEM_ARBITER_STATS_EN
            chk("stat_grants", 64'(stat_grants), {32'(m_cnt[1]), 32'(m_cnt[0])});
`endif
            e_ready = '0; e_we = 0; e_addr = '0; e_wdata = '0; e_found = 0; e_acc = '0;
            e_w = '0; e_b = '0;
            if (m_busy) begin
                e_we    = 1;
                e_addr  = m_idx;
                e_wdata = m_merged;
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    cand = rid_t'((int'(m_ptr) + k) % NREQ);
                    if (!e_found && t_valid[cand]) begin
                        e_found = 1;
                        e_acc   = cand;
                    end
                end
            end
            if (e_found) begin
                e_ready[e_acc] = 1'b1;
                e_addr = t_addr[e_acc][ADDR_W+1:2];
                e_w    = t_wdata[e_acc];
                e_b    = t_be[e_acc];
                if (t_we[e_acc] && e_b == 4'hF) begin
                    e_we    = 1;
                    e_wdata = e_w;
                end
            end
            chk("req_ready", 64'(req_ready), 64'(e_ready));
            chk("mem_we", 64'(mem_we), 64'(e_we));
            if (e_we || e_found) chk("mem_addr", 64'(mem_addr), 64'(e_addr));
            if (e_we) chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
            if (!e_we && !e_found) begin
                chk("idle_mem_addr", 64'(mem_addr), 64'd0);
                chk("idle_mem_wdata", 64'(mem_wdata), 64'd0);
            end
            if (req_ready[0]) dut_log.push_back(0);
            else if (req_ready[1]) dut_log.push_back(1);

            m_rsp_v = '0;
            if (m_busy) begin
                ref_mem[m_idx] = m_merged;
                m_busy = 0;
            end else if (e_found) begin
                m_ptr = rid_t'((int'(e_acc) + 1) % NREQ);
                m_cnt[e_acc]++;
                if (!t_we[e_acc]) begin
                    m_rsp_v[e_acc] = 1'b1;
                    m_rsp_d = ref_mem[e_addr];
                end else if (e_b == 4'hF) begin
                    ref_mem[e_addr] = e_w;
                end else if (e_b != 4'h0) begin
                    m_busy   = 1;
                    m_idx    = e_addr;
                    m_merged = merge_ref(ref_mem[e_addr], e_w, e_b);
                end
            end
        end
    end

    // Starts at posedge+1, returns at posedge+1 after the accept edge.
    task automatic issue(input int r, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be,
                         output logic [ADDR_W-1:0] at_addr);
        rid_t ri;
        int   n;
        ri = rid_t'(r);
        t_we[ri] = we; t_addr[ri] = addr; t_wdata[ri] = wd; t_be[ri] = be; t_valid[ri] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[ri] && n < 50);
        chk("accept_timeout", 64'(req_ready[ri]), 64'd1);
        at_addr = mem_addr;
        @(posedge clk);
        #1;
        t_valid[ri] = 1'b0;
    endtask

    task automatic load(input int r, input logic [31:0] addr, output logic [31:0] rd);
        logic [ADDR_W-1:0] at;
        issue(r, 1'b0, addr, 32'h0, 4'h0, at);
        @(negedge clk);
        chk("load_rsp_pulse", 64'(rsp_valid[rid_t'(r)]), 64'd1);
        rd = rsp_rdata;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        #1;
        chk("async_rst_ready", 64'(req_ready), 64'd0);
        chk("async_rst_mem_we", 64'(mem_we), 64'd0);
        chk("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_requester(input int r, input int n);
        logic [ADDR_W-1:0] at;
        logic [6:0]        idx;
        logic [3:0]        be;
        logic [31:0]       addr;
        int                pick;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            pick = int'($urandom_range(0, 9));
            idx  = (pick < 8) ? 7'(pick) : (pick == 8) ? 7'd127 : 7'($urandom_range(0, 127));
            addr = ($urandom & 32'hFFFF_FE00) | {23'd0, idx, 2'b00} | ($urandom & 32'h3);
            pick = int'($urandom_range(0, 3));
            be   = (pick == 0) ? 4'hF : (pick == 1) ? 4'h0 : 4'($urandom);
            issue(r, 1'($urandom), addr, $urandom, be, at);
        end
    endtask

    logic [31:0]       rd;
    logic [ADDR_W-1:0] at;

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[7'(i)] = init_word(i);
        for (int r = 0; r < NREQ; r++) begin
            t_valid[rid_t'(r)] = 0; t_we[rid_t'(r)] = 0; t_addr[rid_t'(r)] = '0;
            t_wdata[rid_t'(r)] = '0; t_be[rid_t'(r)] = '0;
        end
        mem_init = 1'b1;
        repeat (2) @(posedge clk);
        #1 mem_init = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Round-robin with both requesters continuously loading
        dut_log.delete();
        fork
            begin issue(0, 0, 32'h0, 0, 0, at); issue(0, 0, 32'h4, 0, 0, at); end
            begin issue(1, 0, 32'h8, 0, 0, at); issue(1, 0, 32'hC, 0, 0, at); end
        join
        chk("rr_count", 64'(dut_log.size()), 64'd4);
        if (dut_log.size() == 4) begin
            chk("rr_grant0", 64'(dut_log[0]), 64'd0);
            chk("rr_grant1", 64'(dut_log[1]), 64'd1);
            chk("rr_grant2", 64'(dut_log[2]), 64'd0);
            chk("rr_grant3", 64'(dut_log[3]), 64'd1);
        end

        // Full store then load from the other requester
        issue(0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, at);
        load(1, 32'h10, rd);
        chk("full_store_load", 64'(rd), 64'hDEAD_BEEF);

        // Partial store through RMW, load queued during the RMW cycle
        issue(0, 1, 32'h20, 32'h1122_3344, 4'hF, at);
        issue(0, 1, 32'h20, 32'hAABB_CCDD, 4'b0101, at);
        fork
            load(1, 32'h20, rd);
            begin
                @(negedge clk);
                chk("rmw_ready_low", 64'(req_ready), 64'd0);
                chk("rmw_mem_we", 64'(mem_we), 64'd1);
                chk("rmw_mem_wdata", 64'(mem_wdata), 64'h11BB_33DD);
            end
        join
        chk("partial_store_load", 64'(rd), 64'h11BB_33DD);

        // Store with no byte enables leaves the word alone
        issue(1, 1, 32'h20, 32'hFFFF_FFFF, 4'h0, at);
        load(0, 32'h20, rd);
        chk("be0_store_load", 64'(rd), 64'h11BB_33DD);

        // Reset arriving during the RMW cycle aborts the write
        issue(0, 1, 32'h30, 32'h1122_3344, 4'hF, at);
        issue(0, 1, 32'h30, 32'hCAFE_F00D, 4'b0011, at);
        do_reset();
        chk("rmw_abort_mem", 64'(dmem[7'd12]), 64'h1122_3344);
        load(1, 32'h30, rd);
        chk("rmw_abort_load", 64'(rd), 64'h1122_3344);

        // Top word, low address bits ignored
        issue(0, 1, 32'h1FF, 32'h5A5A_1234, 4'hF, at);
        chk("top_index_addr", 64'(at), 64'd127);
        load(1, 32'h1FC, rd);
        chk("top_index_load", 64'(rd), 64'h5A5A_1234);

        // Pointer back at 0 after reset: req 0 wins a tie
        do_reset();
        dut_log.delete();
        fork
            issue(1, 0, 32'h0, 0, 0, at);
            issue(0, 0, 32'h4, 0, 0, at);
        join
        chk("post_rst_tie", 64'(dut_log.size() > 0 ? dut_log[0] : -1), 64'd0);

`ifdef DMEM_ARBITER_STATS_EN
        do_reset();
        repeat (5) issue(0, 0, 32'h8, 0, 0, at);
        repeat (3) issue(1, 1, 32'h40, 0, 4'h0, at);
        chk("stat_literal", 64'(stat_grants), {32'd3, 32'd5});
        do_reset();
        chk("stat_clear", 64'(stat_grants), 64'd0);
`endif

        fork
            rand_requester(0, 300);
            rand_requester(1, 300);
        join
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) chk("final_mem", 64'(dmem[7'(i)]), 64'(ref_mem[7'(i)]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
